imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. The instruction memory is otherwise read-only to the CPU.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word-count header, then big-endian 32-bit instruction words, then an XOR checksum byte.
- Assembles each group of four bytes into a word and drives it onto the instruction memory write port.
- Holds the CPU in reset (`cpu_hold`) until a load completes with a good checksum.

Parameters:
- `ADDR_W`, 8, word-address width of the instruction memory; capacity is 2^ADDR_W words.

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous active-high reset
- `start`  input  1  single-cycle pulse that begins a load
- `in_data`  input  8  stream byte
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  loader can accept a byte; a byte transfers when `in_valid` and `in_ready` are both high at a rising edge
- `mem_we`  output  1  instruction memory write enable, one-cycle pulse
- `mem_addr`  output  ADDR_W  instruction memory word index
- `mem_wdata`  output  32  instruction word
- `cpu_hold`  output  1  holds the CPU/PC in reset while high
- `done`  output  1  sticky: load finished with a matching checksum
- `err`  output  1  sticky: bad count or checksum mismatch
- `words_loaded`  output  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset (async, immediate):
  - state = IDLE
  - `in_ready` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `cpu_hold` = 1, `done` = 0, `err` = 0, `words_loaded` = 0
  - Memory contents already written are not touched.
- All outputs are registered. `in_ready` is 1 exactly in states HDR_HI, HDR_LO, DATA and CHK.
- States and transitions:
  - IDLE / DONE / ERR: on `start`, go to HDR_HI. In the same edge:
    - clear `done`, `err`, checksum, byte counter, `words_loaded`
    - set `cpu_hold` = 1
  - `start` in any other state is ignored.
  - HDR_HI: on accept, `count[15:8]` = byte; go to HDR_LO.
  - HDR_LO: on accept, `count[7:0]` = byte. Then:
    - if the full count is 0 or greater than 2^ADDR_W, go to ERR;
    - otherwise go to DATA.
  - DATA:
    - Bytes fill `word[31:24]`, `[23:16]`, `[15:8]`, `[7:0]` in arrival order.
    - On the 4th accepted byte, in the next cycle: `mem_we` = 1, `mem_addr` = `words_loaded`[ADDR_W-1:0], `mem_wdata` = assembled word.
    - `words_loaded` increments on that same edge.
    - After the word whose index equals count-1 is written, go to CHK. Otherwise stay in DATA.
    - A byte may be accepted in the same cycle `mem_we` is high. There is no bubble; full throughput is 1 byte/cycle.
  - CHK: on accept, compare the byte with the running checksum.
    - Equal: go to DONE, `done` = 1, `cpu_hold` = 0.
    - Not equal: go to ERR, `err` = 1, `cpu_hold` stays 1.
- Checksum: 8-bit running XOR of every accepted header and data byte. The checksum byte itself is excluded.
- Stalls: `in_valid` low leaves state, counters and partial word unchanged for any number of cycles.
- `in_data` is ignored when no transfer occurs.
- `mem_we` never asserts outside DATA-derived write cycles and is never high for two consecutive cycles for the same address.
- Reset mid-load: abort immediately to IDLE, `cpu_hold` = 1. A partially assembled word is discarded and not written.
- `start` coincident with a byte accept in IDLE/DONE/ERR: no byte is accepted that cycle, because `in_ready` is 0 there.

Test Plan:
1. Nominal load:
   - Stimulus: `start`, then bytes 00 03, 20 10 00 05, 20 11 00 03, 02 11 90 20, A7 with `in_valid` held high.
   - Response: three `mem_we` pulses:
     - addr 0 = 0x20100005
     - addr 1 = 0x20110003
     - addr 2 = 0x02119020
   - `words_loaded` = 3, `done` = 1, `cpu_hold` falls one cycle after A7 is accepted, `err` = 0.
2. Bad checksum:
   - Stimulus: same stream as scenario 1 with A6 as the last byte.
   - Response: all three words are written, `err` = 1, `done` = 0, `cpu_hold` stays 1. A following `start` clears `err`.
3. Bad count:
   - Stimulus: header 01 01 (257, ADDR_W = 8), and separately header 00 00.
   - Response: ERR after HDR_LO, no `mem_we` pulse, `in_ready` = 0.
4. Stalled stream:
   - Stimulus: scenario 1 with `in_valid` low for 3 cycles between every byte, and `in_data` toggling garbage while `in_valid` is low.
   - Response: identical writes and `done`. `mem_we` appears exactly one cycle after each 4th accepted byte.
5. Reset mid-load:
   - Stimulus: assert `rst` after 6 bytes of scenario 1.
   - Response: `in_ready` = 0 and `cpu_hold` = 1 immediately; no write for the partial second word.
   - Stimulus: `start`, then the full scenario 1 stream.
   - Response: the load completes normally.
6. Start while busy:
   - Stimulus: pulse `start` mid-DATA.
   - Response: ignored; the load completes as in scenario 1. A `start` in DONE re-asserts `cpu_hold` and clears `done`.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot-time loader.
// The master side feeds bytes and observes writes; the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: header count, big-endian words written to instruction memory,
// trailing XOR checksum; releases cpu_hold only after a verified load.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] words_loaded
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CHK    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer_s;
    logic [15:0]       hdr_count_s;
    logic              last_word_s;

    assign xfer_s      = bus.in_valid & ready_q;
    assign hdr_count_s = {count_q[15:8], bus.in_data};
    // count has already been range-checked, so it fits in ADDR_W+1 bits here
    assign last_word_s = ((words_q + {{ADDR_W{1'b0}}, 1'b1}) == count_q[ADDR_W:0]);

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        words_d    = words_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR_HI;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    csum_d     = 8'd0;
                    byte_cnt_d = 2'd0;
                    words_d    = '0;
                    hold_d     = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR_HI: begin
                if (xfer_s) begin
                    count_d[15:8] = bus.in_data;
                    csum_d        = csum_q ^ bus.in_data;
                    state_d       = S_HDR_LO;
                end else begin
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_LO: begin
                if (xfer_s) begin
                    count_d = hdr_count_s;
                    csum_d  = csum_q ^ bus.in_data;
                    if ((hdr_count_s == 16'd0) || ({1'b0, hdr_count_s} > CAPACITY)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_HDR_LO;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    csum_d     = csum_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = {word_q, bus.in_data};
                        words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
                        if (last_word_s) begin
                            state_d = S_CHK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        word_d = {word_q[15:0], bus.in_data};
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (xfer_s) begin
                    if (bus.in_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_HDR_HI, S_HDR_LO, S_DATA, S_CHK: ready_d = 1'b1;
            default:                           ready_d = 1'b0;
        endcase
    end

    // State and output registers; memory contents are never touched by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= 16'd0;
            word_q     <= 24'd0;
            byte_cnt_q <= 2'd0;
            csum_q     <= 8'd0;
            words_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_loaded  = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-index model predicts every output each
// cycle, and literal checks pin the documented load scenarios.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic            cpu_hold, done, err;
    logic [ADDR_W:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: progress is tracked as an index into the stream, not as FSM states.
    logic        m_active, m_done, m_err, m_hold, m_we;
    int          m_n, m_cnt, m_words, m_addr;
    logic [7:0]  m_csum, m_b;
    logic [31:0] m_wbuf, m_wdata;

    task automatic m_reset();
        m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1; m_we = 1'b0;
        m_n = 0; m_cnt = 0; m_words = 0; m_addr = 0;
        m_csum = 8'h00; m_wbuf = 32'h0; m_wdata = 32'h0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                m_we = 1'b0;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1; m_n = 0; m_csum = 8'h00; m_words = 0;
                        m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
                    end
                end else if (bus.in_valid) begin
                    m_b = bus.in_data;
                    if (m_n == 0) begin
                        m_cnt  = int'(m_b) * 256;
                        m_csum = m_csum ^ m_b;
                    end else if (m_n == 1) begin
                        m_cnt  = m_cnt + int'(m_b);
                        m_csum = m_csum ^ m_b;
                        if (m_cnt == 0 || m_cnt > CAP) begin
                            m_err = 1'b1; m_active = 1'b0;
                        end
                    end else if (m_n < 2 + 4 * m_cnt) begin
                        m_csum = m_csum ^ m_b;
                        m_wbuf = {m_wbuf[23:0], m_b};
                        if ((m_n - 2) % 4 == 3) begin
                            m_we = 1'b1; m_addr = m_words % CAP; m_wdata = m_wbuf;
                            m_words++;
                        end
                    end else begin
                        if (m_b == m_csum) begin
                            m_done = 1'b1; m_hold = 1'b0;
                        end else begin
                            m_err = 1'b1;
                        end
                        m_active = 1'b0;
                    end
                    m_n++;
                end
            end
        end
    end

    // Per-cycle comparison plus a shadow of the instruction memory.
    logic [31:0] imem [CAP];
    int          n_writes = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("mem_we", 32'(bus.mem_we), 32'(m_we));
            if (m_we) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            check("in_ready", 32'(bus.in_ready), 32'(m_active));
            check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("words_loaded", 32'(words_loaded), 32'(m_words));
            if (bus.mem_we === 1'b1) begin
                imem[bus.mem_addr] = bus.mem_wdata;
                n_writes++;
            end
        end
    end

    logic [7:0] stream [$];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // Sends the stream; gap idle cycles with garbage data after each accept.
    task automatic send(input int gap, input int start_idx);
        for (int i = 0; i < stream.size(); i++) begin
            int waitc = 0;
            bus.in_data  = stream[i];
            bus.in_valid = 1'b1;
            if (i == start_idx) start = 1'b1;
            while (bus.in_ready !== 1'b1 && waitc < 50) begin
                @(posedge clk); #2;
                start = 1'b0;
                waitc++;
            end
            if (waitc >= 50) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: byte %0d not accepted within 50 cycles", i);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #2;
            start        = 1'b0;
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                bus.in_data = 8'($urandom);
                @(posedge clk); #2;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic nominal(input logic [7:0] last);
        stream = {8'h00, 8'h03, 8'h20, 8'h10, 8'h00, 8'h05, 8'h20, 8'h11,
                  8'h00, 8'h03, 8'h02, 8'h11, 8'h90, 8'h20, last};
    endtask

    task automatic check_nominal_done(input string tag, input int w0);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_w0"}, imem[0], 32'h20100005);
        check({tag, "_w1"}, imem[1], 32'h20110003);
        check({tag, "_w2"}, imem[2], 32'h02119020);
        check({tag, "_nwrites"}, 32'(n_writes - w0), 32'd3);
        check({tag, "_words"}, 32'(words_loaded), 32'd3);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [7:0] cs;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Nominal load
        w0 = n_writes;
        pulse_start();
        nominal(8'hA7);
        send(0, -1);
        check_nominal_done("nominal", w0);

        // Bad checksum, then start clears err
        w0 = n_writes;
        pulse_start();
        nominal(8'hA6);
        send(0, -1);
        repeat (3) @(posedge clk);
        #2;
        check("badcs_nwrites", 32'(n_writes - w0), 32'd3);
        check("badcs_err", 32'(err), 32'd1);
        check("badcs_done", 32'(done), 32'd0);
        check("badcs_hold", 32'(cpu_hold), 32'd1);
        pulse_start();
        check("restart_err", 32'(err), 32'd0);

        // Bad counts: 257 and 0
        w0 = n_writes;
        stream = {8'h01, 8'h01};
        send(0, -1);
        repeat (2) @(posedge clk);
        #2;
        check("cnt257_err", 32'(err), 32'd1);
        check("cnt257_ready", 32'(bus.in_ready), 32'd0);
        pulse_start();
        stream = {8'h00, 8'h00};
        send(0, -1);
        repeat (2) @(posedge clk);
        #2;
        check("cnt0_err", 32'(err), 32'd1);
        check("cnt0_ready", 32'(bus.in_ready), 32'd0);
        check("badcnt_nwrites", 32'(n_writes - w0), 32'd0);

        // Full-capacity load of 256 words
        pulse_start();
        stream = {8'h01, 8'h00};
        cs = 8'h01;
        for (int j = 0; j < 4 * CAP; j++) begin
            stream.push_back(8'(j));
            cs = cs ^ 8'(j);
        end
        stream.push_back(cs);
        send(0, -1);
        repeat (3) @(posedge clk);
        #2;
        check("full_done", 32'(done), 32'd1);
        check("full_words", 32'(words_loaded), 32'd256);
        check("full_last", imem[255], 32'hFCFDFEFF);

        // Stalled stream with garbage between bytes
        w0 = n_writes;
        pulse_start();
        nominal(8'hA7);
        send(3, -1);
        check_nominal_done("stall", w0);

        // Reset mid-load after six bytes
        w0 = n_writes;
        pulse_start();
        nominal(8'hA7);
        stream = stream[0:5];
        send(0, -1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check("midrst_nwrites", 32'(n_writes - w0), 32'd1);
        w0 = n_writes;
        pulse_start();
        nominal(8'hA7);
        send(0, -1);
        check_nominal_done("after_rst", w0);

        // Start while busy is ignored; start in DONE restarts
        w0 = n_writes;
        pulse_start();
        nominal(8'hA7);
        send(0, 7);
        check_nominal_done("busy_start", w0);
        pulse_start();
        check("redo_done", 32'(done), 32'd0);
        check("redo_hold", 32'(cpu_hold), 32'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
